// File: rtl/game_2048_pkg.sv
// Shared constants and types for the 2048 control sequencer.
package game_2048_pkg;

   // Default cell width and the cell value that ends the game as a win (2^11 = 2048)
   localparam int NUM_WIDTH = 4;
   localparam int WIN_VALUE = 11;

   // Move direction encodings presented on mv_dir
   localparam logic [1:0] DIR_L = 2'd0;
   localparam logic [1:0] DIR_R = 2'd1;
   localparam logic [1:0] DIR_U = 2'd2;
   localparam logic [1:0] DIR_D = 2'd3;

   // Sequencer states
   typedef enum logic [3:0] {
      ST_INIT_CLR,
      ST_INIT_SP1,
      ST_INIT_SP2,
      ST_IDLE,
      ST_MOVE,
      ST_SPAWN,
      ST_CHECK,
      ST_WON,
      ST_LOST
   } state_t;

endpackage

// File: rtl/board_eval_2048.sv
// Combinational board evaluation: any winning cell, any empty cell, and any
// pair of equal horizontally or vertically adjacent cells.
module board_eval_2048 #(
   parameter int NUM_WIDTH = game_2048_pkg::NUM_WIDTH,
   parameter int WIN_VALUE = game_2048_pkg::WIN_VALUE
) (
   input  logic [0:NUM_WIDTH*16-1] board,
   output logic                    has_win,
   output logic                    has_empty,
   output logic                    has_merge
);
   import game_2048_pkg::*;

   localparam logic [NUM_WIDTH-1:0] WIN_CELL = WIN_VALUE[NUM_WIDTH-1:0];

   logic [NUM_WIDTH-1:0] cells [16];
   logic [15:0]          cellWin;
   logic [15:0]          cellEmpty;
   logic [11:0]          horizEq;
   logic [11:0]          vertEq;

   genvar gi;
   generate
      // Unpack cells and flag win / empty per cell
      for (gi = 0; gi < 16; gi++) begin : gCell
         assign cells[gi]     = board[gi*NUM_WIDTH +: NUM_WIDTH];
         assign cellWin[gi]   = (cells[gi] >= WIN_CELL);
         assign cellEmpty[gi] = (cells[gi] == '0);
      end
      // Three horizontal neighbour pairs per row
      for (gi = 0; gi < 12; gi++) begin : gHoriz
         localparam int K = (gi / 3) * 4 + (gi % 3);
         assign horizEq[gi] = (cells[K] == cells[K+1]);
      end
      // Cell above / cell below for the top three rows
      for (gi = 0; gi < 12; gi++) begin : gVert
         assign vertEq[gi] = (cells[gi] == cells[gi+4]);
      end
   endgenerate

   assign has_win   = |cellWin;
   assign has_empty = |cellEmpty;
   assign has_merge = (|horizEq) | (|vertEq);

endmodule

// File: rtl/game_ctrl_2048.sv
// 2048 control sequencer: button front end, direction arbitration with a
// one-deep pending slot, and the req/done command sequencer for the board
// datapath with move counting and win/lose evaluation.
module game_ctrl_2048 #(
   parameter int NUM_WIDTH = game_2048_pkg::NUM_WIDTH,
   parameter int WIN_VALUE = game_2048_pkg::WIN_VALUE
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    btnL,
   input  logic                    btnR,
   input  logic                    btnU,
   input  logic                    btnD,
   input  logic                    btnC,
   input  logic [0:NUM_WIDTH*16-1] board,
   output logic                    mv_req,
   output logic [1:0]              mv_dir,
   input  logic                    mv_done,
   input  logic                    mv_changed,
   output logic                    spawn_req,
   input  logic                    spawn_done,
   output logic                    clear_req,
   output logic                    busy,
   output logic                    won,
   output logic                    lost,
   output logic [15:0]             move_count
);
   import game_2048_pkg::*;

   // Button bits: 0 L, 1 R, 2 U, 3 D, 4 C
   logic [4:0] btnRaw;
   logic [4:0] btnEdge;
   assign btnRaw = {btnC, btnD, btnU, btnR, btnL};

   genvar gi;
   generate
      for (gi = 0; gi < 5; gi++) begin : gBtnSync
         logic syncStage1Reg;
         logic syncStage2Reg;
         logic prevReg;
         // Two-flop synchroniser followed by a previous-value flop for edge detect
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               syncStage1Reg <= 1'b0;
               syncStage2Reg <= 1'b0;
               prevReg       <= 1'b0;
            end else begin
               syncStage1Reg <= btnRaw[gi];
               syncStage2Reg <= syncStage1Reg;
               prevReg       <= syncStage2Reg;
            end
         end
         assign btnEdge[gi] = syncStage2Reg & ~prevReg;
      end
   endgenerate

   logic       anyDir;
   logic       newGame;
   logic [1:0] arbDir;
   assign anyDir  = |btnEdge[3:0];
   assign newGame = btnEdge[4];

   // Fixed-priority arbitration of simultaneous direction edges: L > R > U > D
   always_comb begin
      arbDir = DIR_D;
      if (btnEdge[0])      arbDir = DIR_L;
      else if (btnEdge[1]) arbDir = DIR_R;
      else if (btnEdge[2]) arbDir = DIR_U;
   end

   logic hasWin;
   logic hasEmpty;
   logic hasMerge;

   board_eval_2048 #(
      .NUM_WIDTH (NUM_WIDTH),
      .WIN_VALUE (WIN_VALUE)
   ) boardEval (
      .board     (board),
      .has_win   (hasWin),
      .has_empty (hasEmpty),
      .has_merge (hasMerge)
   );

   state_t      stateReg, stateNext;
   logic [1:0]  mvDirReg, mvDirNext;
   logic        mvReqReg, mvReqNext;
   logic        spawnReqReg, spawnReqNext;
   logic        clearReqReg, clearReqNext;
   logic        busyReg, busyNext;
   logic        wonReg, wonNext;
   logic        lostReg, lostNext;
   logic [15:0] countReg, countNext;
   logic        pendValidReg, pendValidNext;
   logic [1:0]  pendDirReg, pendDirNext;

   logic busyState;
   assign busyState = !(stateReg inside {ST_IDLE, ST_WON, ST_LOST});

   // Next-state, pending slot, counters and registered-output decode
   always_comb begin
      stateNext     = stateReg;
      mvDirNext     = mvDirReg;
      wonNext       = wonReg;
      lostNext      = lostReg;
      countNext     = countReg;
      pendValidNext = pendValidReg;
      pendDirNext   = pendDirReg;

      // A direction seen while a command is in flight waits in the slot if it is free
      if (busyState && anyDir && !pendValidReg) begin
         pendValidNext = 1'b1;
         pendDirNext   = arbDir;
      end

      case (stateReg)
         ST_INIT_CLR: begin
            // Dwell until the clear pulse has been driven for one cycle
            if (clearReqReg) stateNext = ST_INIT_SP1;
         end
         ST_INIT_SP1: begin
            if (spawn_done && spawnReqReg) stateNext = ST_INIT_SP2;
         end
         ST_INIT_SP2: begin
            if (spawn_done && spawnReqReg) stateNext = ST_IDLE;
         end
         ST_IDLE: begin
            if (newGame) begin
               stateNext = ST_INIT_CLR;
            end else if (pendValidReg) begin
               stateNext     = ST_MOVE;
               mvDirNext     = pendDirReg;
               pendValidNext = 1'b0;
            end else if (anyDir) begin
               stateNext = ST_MOVE;
               mvDirNext = arbDir;
            end
         end
         ST_MOVE: begin
            if (mv_done && mvReqReg) begin
               if (mv_changed) begin
                  if (countReg != 16'hFFFF) countNext = countReg + 16'd1;
                  stateNext = ST_SPAWN;
               end else begin
                  stateNext = ST_IDLE;
               end
            end
         end
         ST_SPAWN: begin
            if (spawn_done && spawnReqReg) stateNext = ST_CHECK;
         end
         ST_CHECK: begin
            if (hasWin) begin
               stateNext = ST_WON;
               wonNext   = 1'b1;
            end else if (!hasEmpty && !hasMerge) begin
               stateNext = ST_LOST;
               lostNext  = 1'b1;
            end else begin
               stateNext = ST_IDLE;
            end
         end
         ST_WON, ST_LOST: begin
            if (newGame) begin
               stateNext = ST_INIT_CLR;
               wonNext   = 1'b0;
               lostNext  = 1'b0;
               countNext = 16'd0;
            end
         end
         default: stateNext = ST_INIT_CLR;
      endcase

      // Terminal states and a fresh game start with an empty slot
      if ((stateNext != stateReg) && (stateNext inside {ST_WON, ST_LOST, ST_INIT_CLR}))
         pendValidNext = 1'b0;

      // Spawn requests drop for at least a cycle after each accepted done,
      // so back-to-back init spawns appear as two distinct requests
      mvReqNext    = (stateNext == ST_MOVE);
      spawnReqNext = (stateNext inside {ST_INIT_SP1, ST_INIT_SP2, ST_SPAWN})
                     && !(spawnReqReg && spawn_done);
      clearReqNext = (stateReg == ST_INIT_CLR) && !clearReqReg;
      busyNext     = !(stateNext inside {ST_IDLE, ST_WON, ST_LOST});
   end

   // State and registered outputs; reset drops any request immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stateReg     <= ST_INIT_CLR;
         mvDirReg     <= DIR_L;
         mvReqReg     <= 1'b0;
         spawnReqReg  <= 1'b0;
         clearReqReg  <= 1'b0;
         busyReg      <= 1'b1;
         wonReg       <= 1'b0;
         lostReg      <= 1'b0;
         countReg     <= 16'd0;
         pendValidReg <= 1'b0;
         pendDirReg   <= DIR_L;
      end else begin
         stateReg     <= stateNext;
         mvDirReg     <= mvDirNext;
         mvReqReg     <= mvReqNext;
         spawnReqReg  <= spawnReqNext;
         clearReqReg  <= clearReqNext;
         busyReg      <= busyNext;
         wonReg       <= wonNext;
         lostReg      <= lostNext;
         countReg     <= countNext;
         pendValidReg <= pendValidNext;
         pendDirReg   <= pendDirNext;
      end
   end

   assign mv_req     = mvReqReg;
   assign mv_dir     = mvDirReg;
   assign spawn_req  = spawnReqReg;
   assign clear_req  = clearReqReg;
   assign busy       = busyReg;
   assign won        = wonReg;
   assign lost       = lostReg;
   assign move_count = countReg;

endmodule

// File: tb/tb_game_ctrl_2048.sv
// Bench for game_ctrl_2048: acts as the board datapath (holds a board image,
// answers req/done handshakes, drops tiles) and checks the sequencer against
// a rule-level model of arbitration, move counting and win/lose outcome.
module tb_game_ctrl_2048;
   localparam int NW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btnL = 1'b0, btnR = 1'b0, btnU = 1'b0, btnD = 1'b0, btnC = 1'b0;
   logic [0:NW*16-1] board;
   logic mv_done = 1'b0, mv_changed = 1'b0, spawn_done = 1'b0;
   logic mv_req, spawn_req, clear_req, busy, won, lost;
   logic [1:0] mv_dir;
   logic [15:0] move_count;

   int checks = 0;
   int errors = 0;
   int expCount = 0;
   int cells [16];

   game_ctrl_2048 #(.NUM_WIDTH(NW), .WIN_VALUE(11)) dut (
      .clk(clk), .rst(rst),
      .btnL(btnL), .btnR(btnR), .btnU(btnU), .btnD(btnD), .btnC(btnC),
      .board(board),
      .mv_req(mv_req), .mv_dir(mv_dir), .mv_done(mv_done), .mv_changed(mv_changed),
      .spawn_req(spawn_req), .spawn_done(spawn_done), .clear_req(clear_req),
      .busy(busy), .won(won), .lost(lost), .move_count(move_count)
   );

   always #5 clk = ~clk;

   always_comb begin
      board = '0;
      for (int k = 0; k < 16; k++) board[k*NW +: NW] = cells[k][NW-1:0];
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running, errors so far %0d", errors);
      $fatal(1, "watchdog expired");
   end

   // ---------------- reference model ----------------
   // Winner among simultaneously pressed directions, ranked left, right, up, down
   function automatic int ref_winner(input logic [3:0] m);
      for (int i = 0; i < 4; i++) if (m[i]) return i;
      return -1;
   endfunction

   // Game outcome of the current board: 0 play on, 1 won, 2 lost
   function automatic int ref_outcome();
      int result;
      result = 2;
      for (int k = 0; k < 16; k++) if (cells[k] >= 11) return 1;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (cells[r*4+c] == 0) result = 0;
            if (c < 3 && cells[r*4+c] == cells[r*4+c+1]) result = 0;
            if (r < 3 && cells[r*4+c] == cells[(r+1)*4+c]) result = 0;
         end
      end
      return result;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_buttons(input logic [4:0] m);
      btnL = m[0]; btnR = m[1]; btnU = m[2]; btnD = m[3]; btnC = m[4];
   endtask

   task automatic press(input logic [4:0] m);
      set_buttons(m); tick(3); set_buttons(5'd0); tick(3);
   endtask

   task automatic place_tile();
      int empties[$];
      for (int k = 0; k < 16; k++) if (cells[k] == 0) empties.push_back(k);
      if (empties.size() > 0)
         cells[empties[$urandom_range(0, empties.size() - 1)]] = int'($urandom_range(1, 2));
   endtask

   task automatic open_board();
      for (int k = 0; k < 16; k++) cells[k] = int'($urandom_range(0, 9));
      cells[5] = 0; cells[10] = 0;
   endtask

   task automatic checker_board();
      int a, b;
      a = int'($urandom_range(1, 5));
      b = a + int'($urandom_range(1, 4));
      for (int k = 0; k < 16; k++) cells[k] = (((k / 4) + (k % 4)) % 2 == 0) ? a : b;
   endtask

   task automatic serve_spawn(input int delay, output bit ok, output logic reqAfter);
      ok = 1'b0; reqAfter = 1'bx;
      for (int i = 0; i < 40 && !ok; i++) begin
         if (spawn_req === 1'b1) ok = 1'b1; else tick();
      end
      if (ok) begin
         tick(delay);
         place_tile();
         spawn_done = 1'b1; tick(); spawn_done = 1'b0;
         reqAfter = spawn_req;
      end
   endtask

   task automatic serve_init(output int clrSeen, output bit ok, output logic busyAfter);
      bit ok1, ok2;
      logic r1, r2;
      clrSeen = 0; ok = 1'b0; busyAfter = 1'bx;
      for (int i = 0; i < 12 && !ok; i++) begin
         if (i == 3) set_buttons(5'd0);
         if (clear_req === 1'b1) clrSeen++;
         if (spawn_req === 1'b1) ok = 1'b1; else tick();
      end
      set_buttons(5'd0);
      if (ok) begin
         serve_spawn(0, ok1, r1);
         serve_spawn(int'($urandom_range(0, 2)), ok2, r2);
         ok = ok1 && ok2;
         busyAfter = busy;
      end
   endtask

   task automatic start_move(input logic [4:0] m, output bit ok);
      ok = 1'b0;
      set_buttons(m);
      for (int i = 0; i < 8 && !ok; i++) begin
         tick();
         if (mv_req === 1'b1) ok = 1'b1;
      end
      set_buttons(5'd0);
   endtask

   task automatic finish_move(input logic changed);
      mv_done = 1'b1; mv_changed = changed; tick();
      mv_done = 1'b0; mv_changed = 1'b0;
      if (changed && expCount < 65535) expCount++;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      int clr; bit ok; logic b;
      rst = 1'b1; tick(2);
      checks++; if ({mv_req, spawn_req, clear_req, won, lost} !== 5'b0)
         begin errors++; $display("FAIL reset_outputs: got %b want 00000", {mv_req, spawn_req, clear_req, won, lost}); end
      checks++; if (mv_dir !== 2'd0) begin errors++; $display("FAIL reset_dir: got %0d want 0", mv_dir); end
      checks++; if (move_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", move_count); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", busy); end
      rst = 1'b0;
      serve_init(clr, ok, b);
      checks++; if (clr !== 1) begin errors++; $display("FAIL init_clear_pulses: got %0d want 1", clr); end
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL init_spawn: handshake timeout got %b want 1", ok); end
      checks++; if (b !== 1'b0) begin errors++; $display("FAIL init_busy: got %b want 0", b); end
      checks++; if (move_count !== 16'd0) begin errors++; $display("FAIL init_count: got %0d want 0", move_count); end
      expCount = 0;
   endtask

   task automatic test_move_random();
      logic [3:0] mask; int expDir, kind, outcome, clr; logic changed, r, b; bit ok;
      for (int it = 0; it < 10; it++) begin
         mask    = 4'($urandom_range(1, 15));
         expDir  = ref_winner(mask);
         changed = 1'($urandom_range(0, 1));
         set_buttons({1'b0, mask});
         tick(2);
         checks++; if (mv_req !== 1'b0) begin errors++; $display("FAIL move_latency_early: got %b want 0", mv_req); end
         tick();
         checks++; if (mv_req !== 1'b1) begin errors++; $display("FAIL move_latency: got %b want 1", mv_req); end
         checks++; if (mv_dir !== 2'(expDir)) begin errors++; $display("FAIL move_dir: got %0d want %0d", mv_dir, expDir); end
         tick(int'($urandom_range(0, 3)));
         checks++; if ({mv_req, mv_dir} !== {1'b1, 2'(expDir)})
            begin errors++; $display("FAIL move_hold: got req %b dir %0d want 1/%0d", mv_req, mv_dir, expDir); end
         set_buttons(5'd0);
         if (changed) begin
            kind = int'($urandom_range(0, 2));
            if (kind == 0) open_board();
            else if (kind == 1) for (int k = 0; k < 16; k++) cells[k] = int'($urandom_range(0, 12));
            else checker_board();
         end
         finish_move(changed);
         checks++; if (mv_req !== 1'b0) begin errors++; $display("FAIL move_req_drop: got %b want 0", mv_req); end
         checks++; if (move_count !== 16'(expCount)) begin errors++; $display("FAIL move_count: got %0d want %0d", move_count, expCount); end
         outcome = 0;
         if (changed) begin
            checks++; if (spawn_req !== 1'b1) begin errors++; $display("FAIL spawn_rise: got %b want 1", spawn_req); end
            serve_spawn(int'($urandom_range(0, 3)), ok, r);
            checks++; if ({ok, r} !== 2'b10) begin errors++; $display("FAIL spawn_handshake: got ok %b req %b want 1/0", ok, r); end
            outcome = ref_outcome();
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL check_busy: got %b want 1", busy); end
            tick();
            checks++; if ({won, lost, busy} !== {outcome == 1, outcome == 2, 1'b0})
               begin errors++; $display("FAIL check_result: got won %b lost %b busy %b want outcome %0d", won, lost, busy, outcome); end
         end else begin
            checks++; if ({spawn_req, busy} !== 2'b00) begin errors++; $display("FAIL nochange_idle: got spawn %b busy %b want 0/0", spawn_req, busy); end
         end
         tick(4);
         checks++; if (mv_req !== 1'b0) begin errors++; $display("FAIL losers_dropped: got %b want 0", mv_req); end
         $display("move %0d: buttons %b dir %0d changed %0b outcome %0d count %0d", it, mask, expDir, changed, outcome, move_count);
         if (outcome != 0) begin
            set_buttons(5'b10000);
            serve_init(clr, ok, b);
            checks++; if ({clr == 1, ok, b, won, lost} !== 5'b11000)
               begin errors++; $display("FAIL restart: got clr %0d ok %b busy %b won %b lost %b", clr, ok, b, won, lost); end
            checks++; if (move_count !== 16'd0) begin errors++; $display("FAIL restart_count: got %0d want 0", move_count); end
            expCount = 0;
         end
      end
   endtask

   task automatic test_pending();
      bit ok; logic r;
      start_move(5'b00001, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL pend_start: timeout got %b want 1", ok); end
      open_board();
      finish_move(1'b1);
      press(5'b00010);
      press(5'b00100);
      checks++; if (spawn_req !== 1'b1) begin errors++; $display("FAIL pend_spawn_held: got %b want 1", spawn_req); end
      serve_spawn(0, ok, r);
      checks++; if ({ok, r} !== 2'b10) begin errors++; $display("FAIL pend_spawn: got ok %b req %b want 1/0", ok, r); end
      tick();
      checks++; if ({busy, mv_req} !== 2'b00) begin errors++; $display("FAIL pend_idle: got busy %b req %b want 0/0", busy, mv_req); end
      tick();
      checks++; if ({mv_req, mv_dir} !== 3'b101) begin errors++; $display("FAIL pend_move: got req %b dir %0d want 1/1", mv_req, mv_dir); end
      finish_move(1'b0);
      tick(5);
      checks++; if (mv_req !== 1'b0) begin errors++; $display("FAIL pend_second_dropped: got %b want 0", mv_req); end
      $display("pending: R queued during spawn, U dropped, count %0d", move_count);
   endtask

   task automatic test_terminal();
      bit ok; logic r, b; int clr;
      for (int tcase = 0; tcase < 2; tcase++) begin
         start_move(5'b00100, ok);
         checks++; if (ok !== 1'b1) begin errors++; $display("FAIL term_start: timeout got %b want 1", ok); end
         checker_board();
         if (tcase == 0) cells[$urandom_range(0, 15)] = int'($urandom_range(11, 15));
         finish_move(1'b1);
         serve_spawn(1, ok, r);
         tick();
         checks++; if ({won, lost, busy} !== {tcase == 0, tcase == 1, 1'b0})
            begin errors++; $display("FAIL term_flags: got won %b lost %b busy %b want case %0d", won, lost, busy, tcase); end
         press(5'b00001);
         checks++; if ({mv_req, busy, won, lost} !== {2'b00, tcase == 0, tcase == 1})
            begin errors++; $display("FAIL term_dir_ignored: got req %b busy %b won %b lost %b", mv_req, busy, won, lost); end
         set_buttons(5'b10000);
         serve_init(clr, ok, b);
         checks++; if ({clr == 1, ok, b, won, lost} !== 5'b11000)
            begin errors++; $display("FAIL term_newgame: got clr %0d ok %b busy %b won %b lost %b", clr, ok, b, won, lost); end
         checks++; if (move_count !== 16'd0) begin errors++; $display("FAIL term_count_clear: got %0d want 0", move_count); end
         expCount = 0;
         tick(3);
         checks++; if (mv_req !== 1'b0) begin errors++; $display("FAIL term_no_stale: got %b want 0", mv_req); end
         $display("terminal case %0d: flags cleared, new game started", tcase);
      end
   endtask

   task automatic test_idle_misc();
      int clr; bit ok; logic b;
      mv_done = 1'b1; mv_changed = 1'b1; spawn_done = 1'b1; tick();
      mv_done = 1'b0; mv_changed = 1'b0; spawn_done = 1'b0; tick();
      checks++; if ({busy, mv_req, spawn_req} !== 3'b000)
         begin errors++; $display("FAIL stray_done: got busy %b mv %b spawn %b want 000", busy, mv_req, spawn_req); end
      checks++; if (move_count !== 16'(expCount)) begin errors++; $display("FAIL stray_count: got %0d want %0d", move_count, expCount); end
      set_buttons(5'b10001);
      serve_init(clr, ok, b);
      checks++; if ({clr == 1, ok, b} !== 3'b110) begin errors++; $display("FAIL c_beats_l: got clr %0d ok %b busy %b", clr, ok, b); end
      tick(3);
      checks++; if (mv_req !== 1'b0) begin errors++; $display("FAIL c_beats_l_nomove: got %b want 0", mv_req); end
      $display("idle: stray dones ignored, C beat L");
   endtask

   task automatic test_reset_mid();
      int clr; bit ok; logic b;
      start_move(5'b01000, ok);
      checks++; if ({ok, mv_dir} !== 3'b111) begin errors++; $display("FAIL rstmid_start: got ok %b dir %0d want 1/3", ok, mv_dir); end
      #2 rst = 1'b1;
      #1;
      checks++; if ({mv_req, busy, move_count} !== {1'b0, 1'b1, 16'd0})
         begin errors++; $display("FAIL rstmid_async: got req %b busy %b count %0d", mv_req, busy, move_count); end
      @(negedge clk);
      rst = 1'b0;
      expCount = 0;
      serve_init(clr, ok, b);
      checks++; if ({clr == 1, ok, b} !== 3'b110) begin errors++; $display("FAIL rstmid_restart: got clr %0d ok %b busy %b", clr, ok, b); end
      $display("reset mid-move: request dropped, restart done");
   endtask

   initial begin
      test_reset();
      test_move_random();
      test_pending();
      test_terminal();
      test_idle_misc();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/game_ctrl_2048.md
# game_ctrl_2048

Control sequencer for the 2048 board datapath. Synchronises and edge-detects the four direction buttons and the centre (new-game) button, and arbitrates simultaneous presses. It issues one move or spawn command at a time to the board engine over req/done handshakes, counts effective moves and evaluates win/lose on the resulting board. Sits between the top-level button pins and the board datapath; the display reads `board` directly from the datapath.

## Interface
- NUM_WIDTH, 4, bits per cell; cell value n = tile 2^n, 0 = empty
- WIN_VALUE, 11, cell value that wins the game (2048)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- btnL, btnR, btnU, btnD  in  1 each  raw direction buttons, asynchronous
- btnC  in  1  raw new-game button, asynchronous
- board  in  NUM_WIDTH*16  current board; cell k (row k/4, col k%4, k=0 top-left) at bits [k*NUM_WIDTH +: NUM_WIDTH], MSB-first vector [0:NUM_WIDTH*16-1]
- mv_req  out  1  move request, level
- mv_dir  out  2  direction: 0 L, 1 R, 2 U, 3 D; stable while mv_req high
- mv_done  in  1  move complete, 1-cycle pulse
- mv_changed  in  1  board differs after move; valid only with mv_done
- spawn_req  out  1  request one random tile, level
- spawn_done  in  1  spawn complete, 1-cycle pulse
- clear_req  out  1  1-cycle pulse: datapath zeroes board
- busy  out  1  high outside IDLE/WON/LOST
- won, lost  out  1 each  terminal flags
- move_count  out  16  effective (board-changing) moves, saturates at 16'hFFFF

## Operation
- Inputs: each button passes through a 2-flop synchroniser, then a rising-edge detector (sync2 & ~prev).
- Arbitration: simultaneous direction edges resolve with priority L > R > U > D; losers are discarded.
- Pending slot: one entry, plus a valid bit.
  - A direction edge arriving while busy is stored if the slot is empty; later edges are dropped.
  - In IDLE, the pending entry is consumed before any new edge.
  - The slot is cleared on entry to WON, LOST or INIT_CLR.
- FSM states: INIT_CLR, INIT_SP1, INIT_SP2, IDLE, MOVE, SPAWN, CHECK, WON, LOST.
  - INIT_CLR: clear_req for 1 cycle; go to INIT_SP1.
  - INIT_SP1, INIT_SP2: spawn_req until spawn_done; then next state. INIT_SP2 goes to IDLE.
  - IDLE: a direction (pending or new) goes to MOVE with mv_dir latched. A btnC edge goes to INIT_CLR. If both occur in the same cycle, btnC wins.
  - MOVE: mv_req held until mv_done.
    - If mv_changed: move_count+1 (saturating), go to SPAWN.
    - Otherwise go to IDLE; no spawn, no count.
  - SPAWN: spawn_req until spawn_done; go to CHECK.
  - CHECK: one cycle, evaluates `board`.
    - Any cell >= WIN_VALUE: WON (won takes precedence over lost).
    - No zero cell and no equal horizontally/vertically adjacent pair: LOST.
    - Otherwise IDLE.
  - WON/LOST: direction edges ignored. btnC edge: clear won/lost/move_count, go to INIT_CLR.
- btnC is ignored in INIT_*, MOVE, SPAWN and CHECK; a handshake is never abandoned.
- A done pulse arriving while the matching req is low is ignored.

## Timing
- Reset values: mv_req 0, mv_dir 0, spawn_req 0, clear_req 0, won 0, lost 0, move_count 0, busy 1; state INIT_CLR; synchronisers and pending slot cleared.
- clear_req is high for the first cycle after rst deasserts.
- All outputs are registered.
- Button latency: a button first sampled high at edge n in IDLE gives mv_req high after edge n+2.
- Req/done handshake: req rises on entering the state. done is sampled at edge m; req is low after edge m. Minimum req width is 1 cycle (done may be high in the first req cycle).
- move_count updates at the same edge that leaves MOVE.
- CHECK result (won/lost/IDLE) is visible after the edge that leaves CHECK; total spawn_done to busy low is 2 edges.
- rst mid-handshake drops req immediately (asynchronously); the datapath must tolerate an abandoned request.

## Structure
- Package game_2048_pkg:
  - NUM_WIDTH and WIN_VALUE defaults
  - direction encodings DIR_L/R/U/D
  - FSM state enum
- Sub-module board_eval_2048: combinational; inputs board; outputs has_win, has_empty, has_merge. Instantiated once, sampled in CHECK.
- Synchronisers, edge detect, arbiter and FSM are inline.

## Test plan
- Reset release -> clear_req pulses once, then two spawn_req handshakes, then busy=0 in IDLE, move_count=0.
- btnL and btnD rising in the same cycle in IDLE, mv_done+mv_changed=1 after 3 cycles -> mv_dir=0, one spawn_req, move_count=1. btnD is not queued.
- btnR pressed during SPAWN, then btnU also during SPAWN -> after CHECK returns to IDLE, MOVE issued with mv_dir=1 only.
- mv_done with mv_changed=0 -> no spawn_req, move_count unchanged, back to IDLE the next edge.
- Board containing cell value 11 at CHECK -> won=1. Full board with no adjacent equals -> lost=1; btnL then ignored; btnC -> won/lost/move_count cleared, clear_req pulse.
- rst asserted while mv_req high -> mv_req low with no clock edge; restart sequence begins after release.
